// File: rtl/dec_sel_scanner.sv
// Select sequencer for the 2x4 decoder: steps s through its four codes, holding each for dwell+1 cycles.
// Optional SCAN_DOWN_EN adds a dir input; dir=1 scans 3,2,1,0 and loops 0->3.
module dec_sel_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_DOWN_EN
  input  logic               dir,
`endif
  output logic [0:1]         s,
  output logic               s_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic [1:0]         start_code;
  logic [1:0]         term_code;
  logic [1:0]         step_code;

`ifdef SCAN_DOWN_EN
  logic dir_q;
  assign start_code = dir   ? 2'd3 : 2'd0;
  assign term_code  = dir_q ? 2'd0 : 2'd3;
  assign step_code  = dir_q ? s - 2'd1 : s + 2'd1;
`else
  assign start_code = 2'd0;
  assign term_code  = 2'd3;
  assign step_code  = s + 2'd1;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= 2'b00;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
`ifdef SCAN_DOWN_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            s       <= start_code;
            s_valid <= 1'b1;
            busy    <= 1'b1;
            cnt     <= dwell;
            dwell_q <= dwell;
            loop_q  <= loop;
`ifdef SCAN_DOWN_EN
            dir_q   <= dir;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            s       <= 2'b00;
            s_valid <= 1'b0;
            busy    <= 1'b0;
          end else if (pause) begin
            state <= RUN;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (s == term_code && !loop_q) begin
            // One-shot end: s keeps the terminal code while idle.
            state   <= IDLE;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            // Modulo-4 step covers both the normal advance and the loop wrap.
            s   <= step_code;
            cnt <= dwell_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_sel_scanner.sv
// Randomized self-checking bench for dec_sel_scanner (default build, up-scan only).
// Reference model expands each scan into a queue of per-cycle codes and pops it.
module tb_dec_sel_scanner;

  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               pause = 1'b0;
  logic               loop = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [0:1]         s;
  logic               s_valid;
  logic               busy;
  logic               done;

  dec_sel_scanner #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop(loop), .dwell(dwell), .s(s), .s_valid(s_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: q holds the code to show on each remaining cycle of the current pass.
  int q[$];
  int m_s, m_dwell;
  bit m_busy, m_done, m_loop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_s = 0; m_dwell = 0; m_busy = 0; m_done = 0; m_loop = 0;
  endfunction

  function automatic void fill(input int d);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r <= d; r++) q.push_back(c);
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_loop  = loop;
        m_dwell = int'(dwell);
        q.delete();
        fill(m_dwell);
        m_s    = q[0];
        m_busy = 1;
      end
    end else if (stop) begin
      m_busy = 0;
      m_s    = 0;
      q.delete();
    end else if (!pause) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (m_loop) begin
          fill(m_dwell);
          m_s = q[0];
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        m_s = q[0];
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("s",       {30'd0, s}, m_s);
    check("s_valid", {31'd0, s_valid}, {31'd0, m_busy});
    check("busy",    {31'd0, busy}, {31'd0, m_busy});
    check("done",    {31'd0, done}, {31'd0, m_done});
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state
    #2;
    check("rst_s", {30'd0, s}, 0);
    check("rst_valid", {31'd0, s_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start and stop together in IDLE: stay idle
    start = 1; stop = 1;
    cycle();
    start = 0; stop = 0;
    check("startstop_busy", {31'd0, busy}, 0);

    // One-shot dwell=2; inputs changed mid-scan and a stray start must not matter
    start = 1; dwell = 2; loop = 0;
    cycle();
    start = 0; dwell = 7; loop = 1;
    repeat (4) cycle();
    start = 1;
    cycle();
    start = 0;
    repeat (9) cycle();
    check("oneshot_idle", {31'd0, busy}, 0);

    // Start accepted in the done cycle
    start = 1; dwell = 0; loop = 0;
    cycle();
    start = 0;
    n = 0;
    while (!m_done && n < 20) begin cycle(); n++; end
    check("done_seen", {31'd0, m_done}, 1);
    start = 1;
    cycle();
    start = 0;
    check("restart_s", {30'd0, s}, 0);
    check("restart_valid", {31'd0, s_valid}, 1);
    check("restart_done", {31'd0, done}, 0);
    stop = 1;
    cycle();
    stop = 0;

    // Pause for 5 cycles while s=1, dwell=1
    start = 1; dwell = 1; loop = 0;
    cycle();
    start = 0;
    n = 0;
    while (m_s != 1 && n < 20) begin cycle(); n++; end
    check("reach_s1", m_s, 1);
    pause = 1;
    repeat (5) cycle();
    pause = 0;
    repeat (8) cycle();

    // Loop dwell=0 then stop
    start = 1; dwell = 0; loop = 1;
    cycle();
    start = 0;
    repeat (10) cycle();
    stop = 1;
    cycle();
    stop = 0;
    check("stop_s", {30'd0, s}, 0);

    // Async reset mid-scan while s=2
    start = 1; dwell = 3; loop = 1;
    cycle();
    start = 0;
    n = 0;
    while (m_s != 2 && n < 40) begin cycle(); n++; end
    check("reach_s2", {30'd0, s}, 2);
    rst_n = 0;
    #1;
    check("arst_s", {30'd0, s}, 0);
    check("arst_valid", {31'd0, s_valid}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    model_reset();
    cycle();
    rst_n = 1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 40) == 0;
      pause = ($urandom % 6) == 0;
      loop  = ($urandom % 2) == 1;
      dwell = (($urandom % 8) == 0) ? 4'd15 : DWELL_W'($urandom % 4);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
